hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Parametrised successor to the five-stage pipeline's hazard unit.
- Adds the following on top of load-use and branch handling:
  - EX/D operand-forwarding selects.
  - A multi-cycle execution-unit scoreboard (mult/div, HI/LO) with configurable latency.
  - A debug freeze that holds the whole pipe while memory is read out for display.
  - A saturating stall-cycle performance counter.
- Sits beside the pipeline registers; drives IF/IF_ID stall, IF_ID and ID_EX clear, and the EX/ID forwarding muxes.

Parameters:
REG_AW, 5, register address width (2^REG_AW architectural registers; register 0 is hard-wired zero)
MC_LAT, 4, multi-cycle unit latency in cycles (legal 2..255)
PERF_W, 16, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
rs_d  in  REG_AW  source A of the instruction in D
rt_d  in  REG_AW  source B of the instruction in D
use_rs_d  in  1  D instruction reads rs
use_rt_d  in  1  D instruction reads rt
branch_d  in  1  D is a conditional branch (compare in D)
jr_d  in  1  D is a jump-register (reads rs in D)
pcsrc_d  in  1  branch taken or jump resolved in D
mc_use_d  in  1  D needs the MC unit or its result (mult/div/mfhi/mflo)
rs_e  in  REG_AW  source A in EX
rt_e  in  REG_AW  source B in EX
wa_e  in  REG_AW  destination in EX
regwrite_e  in  1  EX instruction writes a register
memtoreg_e  in  1  EX instruction is a load
mc_start_e  in  1  EX instruction launches an MC operation
wa_m  in  REG_AW  destination in MEM
regwrite_m  in  1  MEM instruction writes a register
memtoreg_m  in  1  MEM instruction is a load
wa_w  in  REG_AW  destination in WB
regwrite_w  in  1  WB instruction writes a register
freeze  in  1  debug freeze (memory readout mode)
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX (insert bubble)
fwd_a_d  out  1  D compare operand A from MEM
fwd_b_d  out  1  D compare operand B from MEM
fwd_a_e  out  2  EX operand A select: 00 regfile, 10 MEM, 01 WB
fwd_b_e  out  2  EX operand B select, same encoding
mc_busy  out  1  MC unit occupied
mc_overlap  out  1  sticky error: mc_start_e seen while busy
stall_cnt  out  PERF_W  saturating count of hazard-stall cycles

Behaviour:
Reset
- rst high (async): MC counter=0, mc_overlap=0, stall_cnt=0.
- All combinational outputs forced 0 while rst high.

Match rule
- match(x,y) true only if x==y and y!=0.
- Register 0 never forwards and never stalls.

EX forwarding (combinational)
- fwd_a_e=10 if regwrite_m & match(rs_e,wa_m).
- Else fwd_a_e=01 if regwrite_w & match(rs_e,wa_w).
- Else 00. MEM has priority over WB.
- fwd_b_e is identical, using rt_e.

D forwarding
- fwd_a_d = regwrite_m & match(rs_d,wa_m).
- fwd_b_d same with rt_d.

Stall terms
- lw_stall = memtoreg_e & regwrite_e & ((use_rs_d & match(rs_d,wa_e)) | (use_rt_d & match(rt_d,wa_e))).
- br_stall = (branch_d | jr_d) & [(regwrite_e & D-source matches wa_e) | (memtoreg_m & D-source matches wa_m)].
  - For jr_d only rs counts as a D-source.
- mc_stall = mc_use_d & mc_busy.
- hz = lw_stall | br_stall | mc_stall.

Stall/flush outputs
- stall_f = stall_d = hz | freeze.
- flush_e = hz & ~freeze.
- flush_d = pcsrc_d & ~hz & ~freeze.
- A stalled branch/jump never flushes; it flushes only on the cycle it resolves.

MC scoreboard
- Counter width ceil(log2(MC_LAT+1)).
- Launch: mc_start_e & counter==0 & ~freeze → counter loads MC_LAT at the clock edge.
- Count: counter!=0 & ~freeze → counter decrements by 1.
- freeze holds the counter.
- mc_busy = counter!=0, so mc_busy is high for exactly MC_LAT cycles after the launch edge.
- mc_start_e while counter!=0 and ~freeze: ignored, and mc_overlap sets (sticky until rst).
- Launch and final decrement on the same edge are impossible: counter must be 0 to launch.

Perf counter
- stall_cnt increments each clock with hz & ~freeze.
- Saturates at all-ones; no wrap.

Simultaneous events
- freeze overrides everything: no flush, no bubble, counters hold.
- Taken branch plus stall → stall wins.

Reset mid-operation
- A busy MC unit is abandoned; mc_busy drops immediately (async).

Test Plan:
- lw r2 in EX (wa_e=2, memtoreg_e=1), D add uses rt=2 → stall_f=stall_d=flush_e=1 for 1 cycle; stall_cnt 0→1; the following cycle fwd_b_e=10.
- regwrite_m wa_m=5 and regwrite_w wa_w=5, rs_e=5 → fwd_a_e=10; drop regwrite_m → 01; rs_e=0 with wa_m=0 → 00.
- MC_LAT=4: mc_start_e pulse → mc_busy high exactly 4 cycles; mfhi in D (mc_use_d=1) stalls 4 cycles then proceeds; second mc_start_e during busy → mc_overlap=1 and busy not extended.
- beq in D on r3 with regwrite_e wa_e=3 → 1-cycle stall, flush_d=0 during stall; next cycle pcsrc_d=1 → flush_d=1, fwd_a_d=1 if wa_m=3.
- freeze=1 mid-MC (counter=2) for 10 cycles → stall_f=1, flush_e=0, counter holds 2, stall_cnt unchanged; release → busy 2 more cycles.
- PERF_W=4, continuous hz for 20 cycles → stall_cnt saturates at 15; assert rst asynchronously mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_mc_if
// Groups the signals exchanged between the pipeline and its hazard controller.
//   slave  modport : used by hazard_ctrl_mc (pipeline status in, controls out)
//   master modport : used by the pipeline / testbench driving the controller
// Parameters:
//   REG_AW - register address width
//   PERF_W - stall performance counter width
// -----------------------------------------------------------------------------
interface hazard_ctrl_mc_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
);
    // Decode stage
    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic              use_rs_d;
    logic              use_rt_d;
    logic              branch_d;
    logic              jr_d;
    logic              pcsrc_d;
    logic              mc_use_d;
    // Execute stage
    logic [REG_AW-1:0] rs_e;
    logic [REG_AW-1:0] rt_e;
    logic [REG_AW-1:0] wa_e;
    logic              regwrite_e;
    logic              memtoreg_e;
    logic              mc_start_e;
    // Memory stage
    logic [REG_AW-1:0] wa_m;
    logic              regwrite_m;
    logic              memtoreg_m;
    // Writeback stage
    logic [REG_AW-1:0] wa_w;
    logic              regwrite_w;
    // Debug
    logic              freeze;
    // Controls back to the pipeline
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic              fwd_a_d;
    logic              fwd_b_d;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              mc_busy;
    logic              mc_overlap;
    logic [PERF_W-1:0] stall_cnt;

    modport slave (
        input  rs_d, rt_d, use_rs_d, use_rt_d, branch_d, jr_d, pcsrc_d, mc_use_d,
        input  rs_e, rt_e, wa_e, regwrite_e, memtoreg_e, mc_start_e,
        input  wa_m, regwrite_m, memtoreg_m,
        input  wa_w, regwrite_w,
        input  freeze,
        output stall_f, stall_d, flush_d, flush_e,
        output fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
        output mc_busy, mc_overlap, stall_cnt
    );

    modport master (
        output rs_d, rt_d, use_rs_d, use_rt_d, branch_d, jr_d, pcsrc_d, mc_use_d,
        output rs_e, rt_e, wa_e, regwrite_e, memtoreg_e, mc_start_e,
        output wa_m, regwrite_m, memtoreg_m,
        output wa_w, regwrite_w,
        output freeze,
        input  stall_f, stall_d, flush_d, flush_e,
        input  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
        input  mc_busy, mc_overlap, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_mc
// Hazard unit for the five-stage pipeline: load-use and branch/jr stalls,
// EX and D forwarding selects, a scoreboard for the multi-cycle mult/div unit,
// a debug freeze that holds the whole pipe, and a saturating stall counter.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - hazard_ctrl_mc_if.slave (pipeline status in, stall/flush/fwd out)
//
// MC scoreboard states:
//   state   | meaning
//   MC_IDLE | counter is 0, a launch from EX is accepted
//   MC_BUSY | counter counts MC_LAT..1, mc_busy high, launches are errors
// -----------------------------------------------------------------------------
module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int PERF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_mc_if.slave  bus
);
    localparam int            CW      = $clog2(MC_LAT + 1);
    localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT);
    localparam logic [CW-1:0] MC_ONE  = CW'(1);

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    mc_state_t         mc_state_q, mc_state_d;
    logic [CW-1:0]     mc_cnt_q, mc_cnt_d;
    logic              mc_overlap_q, mc_overlap_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lw_stall;
    logic br_dep_e;
    logic br_dep_m;
    logic br_stall;
    logic mc_busy_w;
    logic mc_stall;
    logic hz;

    // Register 0 is hard-wired zero, so it can never be a producer.
    function automatic logic match(input logic [REG_AW-1:0] x,
                                   input logic [REG_AW-1:0] y);
        return (x == y) && (y != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic              rw_m,
                                           input logic [REG_AW-1:0] wa_m,
                                           input logic              rw_w,
                                           input logic [REG_AW-1:0] wa_w);
        // MEM holds the younger result, so it wins over WB.
        if (rw_m && match(src, wa_m)) begin
            return 2'b10;
        end else if (rw_w && match(src, wa_w)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        lw_stall = bus.memtoreg_e & bus.regwrite_e &
                   ((bus.use_rs_d & match(bus.rs_d, bus.wa_e)) |
                    (bus.use_rt_d & match(bus.rt_d, bus.wa_e)));

        // Branches compare rs and rt in D; jr only reads rs.
        br_dep_e = bus.regwrite_e &
                   ((bus.branch_d & (match(bus.rs_d, bus.wa_e) | match(bus.rt_d, bus.wa_e))) |
                    (bus.jr_d & match(bus.rs_d, bus.wa_e)));
        br_dep_m = bus.memtoreg_m &
                   ((bus.branch_d & (match(bus.rs_d, bus.wa_m) | match(bus.rt_d, bus.wa_m))) |
                    (bus.jr_d & match(bus.rs_d, bus.wa_m)));
        br_stall = br_dep_e | br_dep_m;

        mc_busy_w = (mc_cnt_q != '0);
        mc_stall  = bus.mc_use_d & mc_busy_w;

        hz = lw_stall | br_stall | mc_stall;
    end

    // ------------------------------------------------------------------
    // Pipeline controls; everything is held low while rst is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        bus.stall_f    = ~rst & (hz | bus.freeze);
        bus.stall_d    = ~rst & (hz | bus.freeze);
        bus.flush_e    = ~rst & hz & ~bus.freeze;
        // A stalled branch must not squash the fetch slot until it resolves.
        bus.flush_d    = ~rst & bus.pcsrc_d & ~hz & ~bus.freeze;
        bus.fwd_a_d    = ~rst & bus.regwrite_m & match(bus.rs_d, bus.wa_m);
        bus.fwd_b_d    = ~rst & bus.regwrite_m & match(bus.rt_d, bus.wa_m);
        bus.fwd_a_e    = rst ? 2'b00 :
                         fwd_sel(bus.rs_e, bus.regwrite_m, bus.wa_m, bus.regwrite_w, bus.wa_w);
        bus.fwd_b_e    = rst ? 2'b00 :
                         fwd_sel(bus.rt_e, bus.regwrite_m, bus.wa_m, bus.regwrite_w, bus.wa_w);
        bus.mc_busy    = ~rst & mc_busy_w;
        bus.mc_overlap = ~rst & mc_overlap_q;
        bus.stall_cnt  = rst ? '0 : stall_cnt_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_state_q   <= MC_IDLE;
            mc_cnt_q     <= '0;
            mc_overlap_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            mc_state_q   <= mc_state_d;
            mc_cnt_q     <= mc_cnt_d;
            mc_overlap_q <= mc_overlap_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // MC scoreboard next state; freeze holds everything.
    // ------------------------------------------------------------------
    always_comb begin
        mc_state_d   = mc_state_q;
        mc_cnt_d     = mc_cnt_q;
        mc_overlap_d = mc_overlap_q;

        case (mc_state_q)
            MC_IDLE: begin
                if (bus.mc_start_e && !bus.freeze) begin
                    mc_cnt_d   = MC_LOAD;
                    mc_state_d = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (!bus.freeze) begin
                    mc_cnt_d = mc_cnt_q - MC_ONE;
                    if (mc_cnt_q == MC_ONE) begin
                        mc_state_d = MC_IDLE;
                    end
                    // A second launch is dropped; the unit keeps its original
                    // schedule and the error is latched for software.
                    if (bus.mc_start_e) begin
                        mc_overlap_d = 1'b1;
                    end
                end
            end
            default: begin
                mc_state_d = MC_IDLE;
                mc_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall performance counter, saturating at all-ones.
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz && !bus.freeze && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;
    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int PERF_W = 4;
    localparam int SAT    = (1 << PERF_W) - 1;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_mc_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) bus ();

    hazard_ctrl_mc #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_rem = 0;     // cycles the MC unit still needs
    bit m_ovl = 0;
    int m_cnt = 0;

    function automatic bit mt(input int x, input int y);
        return (x == y) && (y != 0);
    endfunction

    function automatic bit m_hz();
        bit lw, br, mc;
        int rs, rt;
        rs = int'(bus.rs_d);
        rt = int'(bus.rt_d);
        lw = bus.memtoreg_e && bus.regwrite_e &&
             ((bus.use_rs_d && mt(rs, int'(bus.wa_e))) || (bus.use_rt_d && mt(rt, int'(bus.wa_e))));
        br = 0;
        if (bus.branch_d || bus.jr_d) begin
            if (bus.regwrite_e && (mt(rs, int'(bus.wa_e)) || (bus.branch_d && mt(rt, int'(bus.wa_e))))) br = 1;
            if (bus.memtoreg_m && (mt(rs, int'(bus.wa_m)) || (bus.branch_d && mt(rt, int'(bus.wa_m))))) br = 1;
        end
        mc = bus.mc_use_d && (m_rem > 0);
        return lw || br || mc;
    endfunction

    function automatic int m_fwd(input int src);
        if (bus.regwrite_m && mt(src, int'(bus.wa_m))) return 2;
        if (bus.regwrite_w && mt(src, int'(bus.wa_w))) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem <= 0;
            m_ovl <= 0;
            m_cnt <= 0;
        end else if (!bus.freeze) begin
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (bus.mc_start_e) m_ovl <= 1;
            end else if (bus.mc_start_e) begin
                m_rem <= MC_LAT;
            end
            if (m_hz() && m_cnt < SAT) m_cnt <= m_cnt + 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        bit h, f;
        h = !rst && m_hz();
        f = !rst && bus.freeze;
        chk("stall_f", 32'(bus.stall_f), 32'(h || f));
        chk("stall_d", 32'(bus.stall_d), 32'(h || f));
        chk("flush_e", 32'(bus.flush_e), 32'(h && !f));
        chk("flush_d", 32'(bus.flush_d), 32'(!rst && bus.pcsrc_d && !h && !f));
        chk("fwd_a_d", 32'(bus.fwd_a_d), 32'(!rst && bus.regwrite_m && mt(int'(bus.rs_d), int'(bus.wa_m))));
        chk("fwd_b_d", 32'(bus.fwd_b_d), 32'(!rst && bus.regwrite_m && mt(int'(bus.rt_d), int'(bus.wa_m))));
        chk("fwd_a_e", 32'(bus.fwd_a_e), rst ? 32'd0 : 32'(m_fwd(int'(bus.rs_e))));
        chk("fwd_b_e", 32'(bus.fwd_b_e), rst ? 32'd0 : 32'(m_fwd(int'(bus.rt_e))));
        chk("mc_busy", 32'(bus.mc_busy), 32'(!rst && m_rem > 0));
        chk("mc_overlap", 32'(bus.mc_overlap), 32'(!rst && m_ovl));
        chk("stall_cnt", 32'(bus.stall_cnt), rst ? 32'd0 : 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        bus.rs_d = '0; bus.rt_d = '0; bus.use_rs_d = 0; bus.use_rt_d = 0;
        bus.branch_d = 0; bus.jr_d = 0; bus.pcsrc_d = 0; bus.mc_use_d = 0;
        bus.rs_e = '0; bus.rt_e = '0; bus.wa_e = '0; bus.regwrite_e = 0;
        bus.memtoreg_e = 0; bus.mc_start_e = 0;
        bus.wa_m = '0; bus.regwrite_m = 0; bus.memtoreg_m = 0;
        bus.wa_w = '0; bus.regwrite_w = 0; bus.freeze = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busyc, stallc;
        clk = 0;
        rst = 1;
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_mc_busy", 32'(bus.mc_busy), 32'd0);

        // Load-use: lw r2 in EX, add in D reads r2 as rt.
        bus.wa_e = 5'd2; bus.memtoreg_e = 1; bus.regwrite_e = 1;
        bus.rs_d = 5'd1; bus.rt_d = 5'd2; bus.use_rs_d = 1; bus.use_rt_d = 1;
        #2;
        chk("lw_stall_f", 32'(bus.stall_f), 32'd1);
        chk("lw_flush_e", 32'(bus.flush_e), 32'd1);
        step();
        chk("lw_cnt1", 32'(bus.stall_cnt), 32'd1);
        clr();
        bus.rt_e = 5'd2; bus.rs_e = 5'd1; bus.wa_m = 5'd2; bus.regwrite_m = 1; bus.memtoreg_m = 1;
        #2;
        chk("lw_fwd_b_e", 32'(bus.fwd_b_e), 32'd2);
        chk("lw_no_stall", 32'(bus.stall_f), 32'd0);
        step();

        // EX forwarding priority.
        clr();
        bus.regwrite_m = 1; bus.wa_m = 5'd5; bus.regwrite_w = 1; bus.wa_w = 5'd5; bus.rs_e = 5'd5;
        #2 chk("fwd_mem", 32'(bus.fwd_a_e), 32'd2);
        bus.regwrite_m = 0;
        #2 chk("fwd_wb", 32'(bus.fwd_a_e), 32'd1);
        bus.regwrite_m = 1; bus.rs_e = 5'd0; bus.wa_m = 5'd0; bus.wa_w = 5'd0;
        #2 chk("fwd_r0", 32'(bus.fwd_a_e), 32'd0);
        step();

        // MC unit: busy exactly MC_LAT cycles, mfhi waits, overlap ignored.
        clr();
        bus.mc_start_e = 1; bus.mc_use_d = 1;
        step();
        bus.mc_start_e = 0;
        busyc = 0; stallc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busyc += int'(bus.mc_busy);
            stallc += int'(bus.stall_f);
            step();
            bus.mc_start_e = (i == 1);
        end
        chk("mc_busy_cycles", 32'(busyc), 32'd4);
        chk("mc_stall_cycles", 32'(stallc), 32'd4);
        chk("mc_overlap", 32'(bus.mc_overlap), 32'd1);
        chk("mc_cnt5", 32'(bus.stall_cnt), 32'd5);

        // beq r3,r4 with r3 still in EX: stall, no flush until resolved.
        clr();
        bus.branch_d = 1; bus.rs_d = 5'd3; bus.rt_d = 5'd4; bus.pcsrc_d = 1;
        bus.regwrite_e = 1; bus.wa_e = 5'd3;
        #2;
        chk("br_stall", 32'(bus.stall_f), 32'd1);
        chk("br_flush_d_held", 32'(bus.flush_d), 32'd0);
        step();
        bus.regwrite_e = 0; bus.wa_e = 5'd0; bus.regwrite_m = 1; bus.wa_m = 5'd3;
        #2;
        chk("br_resolve_stall", 32'(bus.stall_f), 32'd0);
        chk("br_flush_d", 32'(bus.flush_d), 32'd1);
        chk("br_fwd_a_d", 32'(bus.fwd_a_d), 32'd1);
        step();

        // Freeze with the MC counter at 2.
        clr();
        bus.mc_start_e = 1;
        step();
        bus.mc_start_e = 0;
        step();
        step();
        bus.freeze = 1; bus.mc_use_d = 1;
        repeat (10) step();
        chk("frz_stall_f", 32'(bus.stall_f), 32'd1);
        chk("frz_flush_e", 32'(bus.flush_e), 32'd0);
        chk("frz_busy", 32'(bus.mc_busy), 32'd1);
        chk("frz_cnt", 32'(bus.stall_cnt), 32'd6);
        bus.freeze = 0;
        busyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busyc += int'(bus.mc_busy);
            step();
        end
        chk("frz_release_busy", 32'(busyc), 32'd2);
        chk("frz_cnt8", 32'(bus.stall_cnt), 32'd8);

        // Mixed vectors over a small register set, checked by the model.
        for (int i = 0; i < 60; i++) begin
            bus.rs_d = 5'($urandom_range(0, 3)); bus.rt_d = 5'($urandom_range(0, 3));
            bus.rs_e = 5'($urandom_range(0, 3)); bus.rt_e = 5'($urandom_range(0, 3));
            bus.wa_e = 5'($urandom_range(0, 3)); bus.wa_m = 5'($urandom_range(0, 3));
            bus.wa_w = 5'($urandom_range(0, 3));
            bus.use_rs_d = 1'($urandom); bus.use_rt_d = 1'($urandom);
            bus.branch_d = ($urandom_range(0, 3) == 0); bus.jr_d = ($urandom_range(0, 3) == 0);
            bus.pcsrc_d = 1'($urandom); bus.mc_use_d = 1'($urandom);
            bus.regwrite_e = 1'($urandom); bus.memtoreg_e = 1'($urandom);
            bus.regwrite_m = 1'($urandom); bus.memtoreg_m = 1'($urandom);
            bus.regwrite_w = 1'($urandom);
            bus.mc_start_e = ($urandom_range(0, 7) == 0);
            bus.freeze = ($urandom_range(0, 5) == 0);
            step();
        end

        // Saturation, then async reset with the MC unit busy.
        clr();
        repeat (6) step();
        bus.wa_e = 5'd2; bus.memtoreg_e = 1; bus.regwrite_e = 1;
        bus.rt_d = 5'd2; bus.use_rt_d = 1;
        repeat (20) step();
        chk("sat_cnt", 32'(bus.stall_cnt), 32'(SAT));
        bus.mc_start_e = 1;
        step();
        bus.mc_start_e = 0;
        step();
        chk("pre_rst_busy", 32'(bus.mc_busy), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_stall_f", 32'(bus.stall_f), 32'd0);
        chk("arst_flush_e", 32'(bus.flush_e), 32'd0);
        chk("arst_busy", 32'(bus.mc_busy), 32'd0);
        chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("arst_overlap", 32'(bus.mc_overlap), 32'd0);
        step();
        clr();
        rst = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
